// File: rtl/hdu_pkg.sv
// Shared constants and helpers for the scoreboard-based hazard detection unit.
// Latency classes, jump opcodes and the counter preset derived from a class.
package hdu_pkg;

   localparam logic [1:0] LAT_ALU  = 2'd0;
   localparam logic [1:0] LAT_LOAD = 2'd1;
   localparam logic [1:0] LAT_MUL  = 2'd2;
   localparam logic [1:0] LAT_RSVD = 2'd3;

   localparam logic [1:0] JMP_NONE   = 2'd0;
   localparam logic [1:0] JMP_JUMP   = 2'd1;
   localparam logic [1:0] JMP_BRANCH = 2'd2;
   localparam logic [1:0] JMP_JR     = 2'd3;

   // Cycles a destination stays pending after issue; ALU results forward next cycle.
   function automatic int unsigned lat_set_val(input logic [1:0]  lat_class,
                                               input int unsigned load_lat,
                                               input int unsigned mul_lat);
      int unsigned val;
      val = 0;
      case (lat_class)
         LAT_LOAD: val = load_lat;
         LAT_MUL:  val = mul_lat;
         default:  val = 0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/hdu_scoreboard_ctrl_if.sv
// ID-stage hazard interface: decode/stall inputs towards the HDU and the
// pipeline enables/flushes it returns. master = pipeline side, slave = HDU.
interface hdu_scoreboard_ctrl_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned PERF_W = 16
);

   logic              IC_stall;
   logic              DC_stall;
   logic [REG_AW-1:0] ID_Rs;
   logic [REG_AW-1:0] ID_Rt;
   logic              ID_UseRs;
   logic              ID_UseRt;
   logic [REG_AW-1:0] ID_WR;
   logic              ID_RegWrite;
   logic [1:0]        ID_LatClass;
   logic [1:0]        EX_JumpOP;

   logic              PCWrite;
   logic              IF_IDWrite;
   logic              ID_EXWrite;
   logic              EX_MWrite;
   logic              M_WBWrite;
   logic              IF_Flush;
   logic              ID_Flush;
   logic [PERF_W-1:0] perf_stall_cnt;

   modport master (
      output IC_stall, DC_stall, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
             ID_WR, ID_RegWrite, ID_LatClass, EX_JumpOP,
      input  PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite,
             IF_Flush, ID_Flush, perf_stall_cnt
   );

   modport slave (
      input  IC_stall, DC_stall, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
             ID_WR, ID_RegWrite, ID_LatClass, EX_JumpOP,
      output PCWrite, IF_IDWrite, ID_EXWrite, EX_MWrite, M_WBWrite,
             IF_Flush, ID_Flush, perf_stall_cnt
   );

endinterface

// File: rtl/hdu_sb_regfile.sv
// Per-register countdown scoreboard: a non-zero count means the register's
// result is not yet forwardable. Entry 0 is constant zero.
module hdu_sb_regfile
   import hdu_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned CNT_W    = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MUL_LAT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] wr,
   input  logic              set_en,
   input  logic [1:0]        set_class,
   output logic              rs_pend,
   output logic              rt_pend,
   output logic              wr_pend
);

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];
   logic [CNT_W-1:0] set_val;

   assign set_val = CNT_W'(lat_set_val(set_class, LOAD_LAT, MUL_LAT));

   always_comb begin
      rs_pend = 1'b0;
      rt_pend = 1'b0;
      wr_pend = 1'b0;
      for (int r = 1; r < int'(NUM_REGS); r++) begin
         if (rs == REG_AW'(r) && cnt_q[r] != '0) rs_pend = 1'b1;
         if (rt == REG_AW'(r) && cnt_q[r] != '0) rt_pend = 1'b1;
         if (wr == REG_AW'(r) && cnt_q[r] != '0) wr_pend = 1'b1;
      end
   end

   // A set wins over the decrement of the same entry in the same cycle.
   always_comb begin
      cnt_d[0] = '0;
      for (int r = 1; r < int'(NUM_REGS); r++) begin
         cnt_d[r] = cnt_q[r];
         if (!freeze) begin
            if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
            if (set_en && wr == REG_AW'(r)) cnt_d[r] = set_val;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= '0;
      end else begin
         for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= cnt_d[r];
      end
   end

endmodule

// File: rtl/hdu_scoreboard_ctrl.sv
// Hazard detection unit: resolves freeze/jump/hazard priority into pipeline
// enables and flushes, tracks the non-pipelined multiplier and counts stall cycles.
module hdu_scoreboard_ctrl
   import hdu_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MUL_LAT  = 4,
   parameter int unsigned CNT_W    = 3,
   parameter int unsigned PERF_W   = 16
) (
   input logic                  clk,
   input logic                  rst,
   hdu_scoreboard_ctrl_if.slave bus
);

   logic              freeze;
   logic              jump;
   logic              raw;
   logic              waw;
   logic              struct_haz;
   logic              hazard;
   logic              issue;
   logic              is_mul;
   logic              set_en;
   logic              rs_pend;
   logic              rt_pend;
   logic              wr_pend;
   logic [CNT_W-1:0]  mul_busy_q;
   logic [CNT_W-1:0]  mul_busy_d;
   logic [PERF_W-1:0] perf_q;
   logic [PERF_W-1:0] perf_d;

   assign freeze     = bus.IC_stall | bus.DC_stall;
   assign jump       = bus.EX_JumpOP != JMP_NONE;
   assign is_mul     = bus.ID_LatClass == LAT_MUL;
   assign raw        = (bus.ID_UseRs & rs_pend) | (bus.ID_UseRt & rt_pend);
   assign waw        = bus.ID_RegWrite & wr_pend;
   assign struct_haz = is_mul & (mul_busy_q != '0);
   assign hazard     = raw | waw | struct_haz;
   assign issue      = ~freeze & ~jump & ~hazard;

   // Only loads and multiplies leave a destination pending; r0 is never tracked.
   assign set_en = issue & bus.ID_RegWrite & (bus.ID_WR != '0) &
                   ((bus.ID_LatClass == LAT_LOAD) | is_mul);

   hdu_sb_regfile #(
      .NUM_REGS (NUM_REGS),
      .REG_AW   (REG_AW),
      .CNT_W    (CNT_W),
      .LOAD_LAT (LOAD_LAT),
      .MUL_LAT  (MUL_LAT)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .freeze    (freeze),
      .rs        (bus.ID_Rs),
      .rt        (bus.ID_Rt),
      .wr        (bus.ID_WR),
      .set_en    (set_en),
      .set_class (bus.ID_LatClass),
      .rs_pend   (rs_pend),
      .rt_pend   (rt_pend),
      .wr_pend   (wr_pend)
   );

   always_comb begin
      bus.PCWrite    = 1'b1;
      bus.IF_IDWrite = 1'b1;
      bus.ID_EXWrite = 1'b1;
      bus.EX_MWrite  = 1'b1;
      bus.M_WBWrite  = 1'b1;
      bus.IF_Flush   = 1'b1;
      bus.ID_Flush   = 1'b1;
      if (freeze) begin
         bus.PCWrite    = 1'b0;
         bus.IF_IDWrite = 1'b0;
         bus.ID_EXWrite = 1'b0;
         bus.EX_MWrite  = 1'b0;
         bus.M_WBWrite  = 1'b0;
      end else if (jump) begin
         // ID instruction is discarded, so any hazard it carries is moot.
         bus.IF_Flush = 1'b0;
         bus.ID_Flush = 1'b0;
      end else if (hazard) begin
         bus.PCWrite    = 1'b0;
         bus.IF_IDWrite = 1'b0;
         bus.ID_Flush   = 1'b0;
      end
   end

   always_comb begin
      mul_busy_d = mul_busy_q;
      if (!freeze) begin
         if (mul_busy_q != '0) mul_busy_d = mul_busy_q - 1'b1;
         if (issue && is_mul) mul_busy_d = CNT_W'(MUL_LAT);
      end
   end

   always_comb begin
      perf_d = perf_q;
      if (!bus.PCWrite && perf_q != '1) perf_d = perf_q + 1'b1;
   end

   assign bus.perf_stall_cnt = perf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_busy_q <= '0;
         perf_q     <= '0;
      end else begin
         mul_busy_q <= mul_busy_d;
         perf_q     <= perf_d;
      end
   end

endmodule

// File: tb/tb_hdu_scoreboard_ctrl.sv
// Scoreboard bench for hdu_scoreboard_ctrl: a reference model predicts each
// cycle's enables/flushes, queues them, and compares when the DUT settles.
module tb_hdu_scoreboard_ctrl;
   import hdu_pkg::*;

   localparam int unsigned LOAD_LAT = 1;
   localparam int unsigned MUL_LAT  = 4;
   localparam int unsigned PW       = 4;
   localparam int          PMAX     = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hdu_scoreboard_ctrl_if #(.REG_AW(5), .PERF_W(PW)) bus ();

   hdu_scoreboard_ctrl #(
      .NUM_REGS (32),
      .REG_AW   (5),
      .LOAD_LAT (LOAD_LAT),
      .MUL_LAT  (MUL_LAT),
      .CNT_W    (3),
      .PERF_W   (PW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int m_cnt [32];
   int m_mul;
   int m_perf;
   logic [6:0] exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_clear();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_mul  = 0;
      m_perf = 0;
   endfunction

   task automatic set_idle();
      bus.IC_stall = 0; bus.DC_stall = 0;
      bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_UseRs = 0; bus.ID_UseRt = 0;
      bus.ID_WR = '0; bus.ID_RegWrite = 0; bus.ID_LatClass = LAT_ALU; bus.EX_JumpOP = JMP_NONE;
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic step(input string tag, input logic ic, input logic dc,
                       input int rs, input logic urs, input int rt, input logic urt,
                       input int wr, input logic rw, input logic [1:0] cls,
                       input logic [1:0] jmp);
      logic fz, jp, hz, iss;
      logic [6:0] exp, got;
      bus.IC_stall = ic; bus.DC_stall = dc;
      bus.ID_Rs = 5'(rs); bus.ID_UseRs = urs; bus.ID_Rt = 5'(rt); bus.ID_UseRt = urt;
      bus.ID_WR = 5'(wr); bus.ID_RegWrite = rw; bus.ID_LatClass = cls; bus.EX_JumpOP = jmp;
      fz = ic | dc;
      jp = jmp != 2'd0;
      hz = (urs && m_cnt[rs] != 0) || (urt && m_cnt[rt] != 0) ||
           (rw && m_cnt[wr] != 0) || (cls == 2'd2 && m_mul != 0);
      if (fz)      exp = 7'b0000011;
      else if (jp) exp = 7'b1111100;
      else if (hz) exp = 7'b0011110;
      else         exp = 7'b1111111;
      iss = !fz && !jp && !hz;
      exp_q.push_back(exp);
      @(negedge clk);
      got = {bus.PCWrite, bus.IF_IDWrite, bus.ID_EXWrite, bus.EX_MWrite, bus.M_WBWrite,
             bus.IF_Flush, bus.ID_Flush};
      check_val(tag, 32'(got), 32'(exp_q.pop_front()));
      @(posedge clk);
      if (!exp[6] && m_perf < PMAX) m_perf++;
      if (!fz) begin
         foreach (m_cnt[i]) if (m_cnt[i] > 0) m_cnt[i]--;
         if (m_mul > 0) m_mul--;
         if (iss && rw && wr != 0 && cls == 2'd1) m_cnt[wr] = LOAD_LAT;
         if (iss && rw && wr != 0 && cls == 2'd2) m_cnt[wr] = MUL_LAT;
         if (iss && cls == 2'd2) m_mul = MUL_LAT;
      end
      #1;
   endtask

   task automatic op(input string tag, input int rs, input logic urs, input int rt,
                     input logic urt, input int wr, input logic rw, input logic [1:0] cls);
      step(tag, 0, 0, rs, urs, rt, urt, wr, rw, cls, JMP_NONE);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0, LAT_ALU, JMP_NONE);
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      #1;
      check_val("perf_async_clr", 32'(bus.perf_stall_cnt), 0);
      #2;
      rst = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic check_perf(input string tag, input int want);
      check_val({tag, "_model"}, 32'(bus.perf_stall_cnt), 32'(m_perf));
      check_val(tag, 32'(bus.perf_stall_cnt), 32'(want));
   endtask

   initial begin
      set_idle();
      model_clear();
      rst = 1'b1;
      #12;
      rst = 1'b0;
      @(posedge clk);
      #1;

      check_perf("rst_perf", 0);
      idle("rst_idle");

      // Load-use: one stall cycle
      op("lu_issue", 0, 0, 0, 0, 5, 1, LAT_LOAD);
      op("lu_stall", 5, 1, 0, 0, 0, 0, LAT_ALU);
      op("lu_go",    5, 1, 0, 0, 0, 0, LAT_ALU);
      check_perf("lu_perf", 1);

      // Multiply dependency then structural stall
      do_reset();
      op("mul_issue", 0, 0, 0, 0, 7, 1, LAT_MUL);
      for (int i = 0; i < 5; i++) op("mul_dep", 0, 0, 7, 1, 8, 1, LAT_ALU);
      check_perf("mul_perf", 4);
      op("mul2_a", 1, 1, 0, 0, 10, 1, LAT_MUL);
      for (int i = 0; i < 5; i++) op("mul2_struct", 2, 1, 0, 0, 11, 1, LAT_MUL);
      check_perf("struct_perf", 8);

      // Freeze during a multiply stall
      do_reset();
      op("fz_mul", 0, 0, 0, 0, 7, 1, LAT_MUL);
      op("fz_dep0", 7, 1, 0, 0, 0, 0, LAT_ALU);
      for (int i = 0; i < 3; i++) step("fz_dc", 0, 1, 7, 1, 0, 0, 0, 0, LAT_ALU, JMP_NONE);
      for (int i = 0; i < 4; i++) op("fz_dep1", 7, 1, 0, 0, 0, 0, LAT_ALU);
      check_perf("fz_perf", 7);

      // Jump overrides hazard; flushed load leaves r9 free
      do_reset();
      op("jmp_ld5", 0, 0, 0, 0, 5, 1, LAT_LOAD);
      step("jmp_flush", 0, 0, 5, 1, 0, 0, 9, 1, LAT_LOAD, JMP_BRANCH);
      op("jmp_r9", 9, 1, 9, 1, 0, 0, LAT_ALU);
      step("ic_over_jmp", 1, 0, 0, 0, 0, 0, 0, 0, LAT_ALU, JMP_JR);
      check_perf("jmp_perf", 1);

      // r0 never pending; WAW stall behind a multiply
      do_reset();
      op("r0_ld", 0, 0, 0, 0, 0, 1, LAT_LOAD);
      op("r0_rd", 0, 1, 0, 1, 0, 0, LAT_ALU);
      op("waw_mul", 0, 0, 0, 0, 3, 1, LAT_MUL);
      for (int i = 0; i < 5; i++) op("waw_alu", 0, 0, 0, 0, 3, 1, LAT_ALU);
      check_perf("waw_perf", 4);

      // Reset mid-multiply clears scoreboard and perf
      do_reset();
      op("rm_mul", 0, 0, 0, 0, 7, 1, LAT_MUL);
      op("rm_dep", 7, 1, 0, 0, 0, 0, LAT_ALU);
      op("rm_dep", 7, 1, 0, 0, 0, 0, LAT_ALU);
      check_perf("rm_pre", 2);
      do_reset();
      op("rm_after", 7, 1, 0, 0, 0, 0, LAT_MUL);
      check_perf("rm_perf", 0);

      // Saturation at 2^PW-1
      do_reset();
      for (int i = 0; i < 20; i++) step("sat_dc", 0, 1, 0, 0, 0, 0, 0, 0, LAT_ALU, JMP_NONE);
      check_perf("sat_perf", 15);

      check_val("queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
